// File: rtl/tdma_slot_scheduler.sv
// tdma_slot_scheduler: time-division slot scheduler for N queues.
// Slot lengths are latched from delta into shadow registers at every frame
// load. Zero-length slots are skipped. slot_start and frame_start pulse in
// the first cycle of each slot and each frame.
// Optional feature macro: TDMA_WORK_CONSERVING_EN. When it is defined, an
// idle slot is lent to the next pending queue, searched cyclically.
module tdma_slot_scheduler #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int REGISTER_SIZE    = 32
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   delta,
  input  logic [NUMBER_OF_QUEUES-1:0]                      pending,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]              selection,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]              grant,
  output logic                                             active,
  output logic                                             slot_start,
  output logic                                             frame_start
);

  localparam int N     = NUMBER_OF_QUEUES;
  localparam int IDX_W = $clog2(NUMBER_OF_QUEUES);

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {LOAD, RUN} state_t;

  state_t                          state_q, state_d;
  logic [N-1:0][REGISTER_SIZE-1:0] shadow_q, shadow_d;
  idx_t                            idx_q, idx_d;
  logic [REGISTER_SIZE-1:0]        cnt_q, cnt_d;
  idx_t                            sel_q, sel_d;
  logic                            active_q, active_d;
  logic                            ss_q, ss_d;
  logic                            fs_q, fs_d;

  idx_t load_idx;
  logic load_any;
  idx_t nxt_idx;
  logic nxt_any;
  logic slot_end;
  idx_t grant_c;

  // Lowest nonzero delta (candidate first slot of a new frame) and lowest
  // nonzero shadow above the current index (next slot in this frame).
  always_comb begin
    load_idx = '0;
    load_any = 1'b0;
    nxt_idx  = '0;
    nxt_any  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (delta[i] != '0) begin
        load_idx = idx_t'(i);
        load_any = 1'b1;
      end
      if ((i > int'(idx_q)) && (shadow_q[i] != '0)) begin
        nxt_idx = idx_t'(i);
        nxt_any = 1'b1;
      end
    end
    // Each slot is timed against its own length; no running frame sum.
    slot_end = (cnt_q == (shadow_q[idx_q] - REGISTER_SIZE'(1)));
  end

  // Next-state and registered-output logic for the LOAD/RUN controller.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    active_d = active_q;
    ss_d     = 1'b0;
    fs_d     = 1'b0;
    if ((state_q == RUN) && !slot_end) begin
      cnt_d = cnt_q + REGISTER_SIZE'(1);
    end else if ((state_q == RUN) && nxt_any) begin
      idx_d = nxt_idx;
      sel_d = nxt_idx;
      cnt_d = '0;
      ss_d  = 1'b1;
    end else begin
      // Frame load: from LOAD, or back-to-back when the last slot expires.
      shadow_d = delta;
      cnt_d    = '0;
      if (load_any) begin
        idx_d    = load_idx;
        sel_d    = load_idx;
        ss_d     = 1'b1;
        fs_d     = 1'b1;
        active_d = 1'b1;
        state_d  = RUN;
      end else begin
        idx_d    = '0;
        sel_d    = '0;
        active_d = 1'b0;
        state_d  = LOAD;
      end
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= LOAD;
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
      active_q <= 1'b0;
      ss_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      ss_q     <= ss_d;
      fs_q     <= fs_d;
    end
  end

`ifdef TDMA_WORK_CONSERVING_EN
  int cand;

  // Lend an idle slot to the first pending queue after the slot owner.
  always_comb begin
    grant_c = sel_q;
    cand    = 0;
    if (!pending[sel_q] && (pending != '0)) begin
      for (int k = N - 1; k >= 1; k--) begin
        cand = (int'(sel_q) + k) % N;
        if (pending[cand]) grant_c = idx_t'(cand);
      end
    end
  end
`else
  logic unused_pending;

  // Strict TDMA: the slot owner is always the served queue.
  always_comb begin
    grant_c        = sel_q;
    unused_pending = ^pending;
  end
`endif

  assign grant       = reset ? '0 : grant_c;
  assign selection   = sel_q;
  assign active      = active_q;
  assign slot_start  = ss_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_tdma_slot_scheduler.sv
// Directed testbench for tdma_slot_scheduler (N=4, 32-bit slot lengths).
// Observed vector per cycle: {selection, grant, active, slot_start, frame_start}.
module tb_tdma_slot_scheduler;

  logic             clock;
  logic             reset;
  logic [3:0][31:0] delta;
  logic [3:0]       pending;
  logic [1:0]       selection;
  logic [1:0]       grant;
  logic             active;
  logic             slot_start;
  logic             frame_start;

  int vectors;
  int miscompares;

  tdma_slot_scheduler #(
    .NUMBER_OF_QUEUES(4),
    .REGISTER_SIZE   (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .delta      (delta),
    .pending    (pending),
    .selection  (selection),
    .grant      (grant),
    .active     (active),
    .slot_start (slot_start),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] pack_exp(int sel, bit act, bit ss, bit fs);
    logic [1:0] s;
    s = sel[1:0];
    return {s, s, act, ss, fs};
  endfunction

  task automatic test_reset();
    logic [6:0] obs;
    reset = 1'b1;
    tick();
    obs = {selection, grant, active, slot_start, frame_start};
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b, expected %b", obs, 7'b0);
    end
  endtask

  task automatic test_basic_frame();
    int         e_sel [10] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3};
    bit         e_ss  [10] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 1};
    logic [6:0] obs, exp;
    delta   = {32'd1, 32'd4, 32'd2, 32'd3};
    pending = 4'b0000;
    test_reset();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      obs = {selection, grant, active, slot_start, frame_start};
      exp = pack_exp(e_sel[i % 10], 1'b1, e_ss[i % 10], (i % 10) == 0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL basic_frame cycle %0d: got %b, expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_zero_slots();
    int         e_sel [7] = '{1, 1, 1, 1, 1, 3, 3};
    bit         e_ss  [7] = '{1, 0, 0, 0, 0, 1, 0};
    logic [6:0] obs, exp;
    delta = {32'd2, 32'd0, 32'd5, 32'd0};
    test_reset();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      obs = {selection, grant, active, slot_start, frame_start};
      exp = pack_exp(e_sel[i % 7], 1'b1, e_ss[i % 7], (i % 7) == 0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL zero_slots cycle %0d: got %b, expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_shadow_update();
    int         e_sel [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
    bit         e_ss  [12] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
    bit         e_fs  [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [6:0] obs, exp;
    delta = {32'd2, 32'd2, 32'd2, 32'd2};
    test_reset();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      obs = {selection, grant, active, slot_start, frame_start};
      exp = pack_exp(e_sel[i], 1'b1, e_ss[i], e_fs[i]);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL shadow_update cycle %0d: got %b, expected %b", i, obs, exp);
      end
      if (i == 2) delta = {32'd1, 32'd1, 32'd1, 32'd1};
    end
  endtask

  task automatic test_all_zero();
    logic [6:0] obs, exp;
    delta = '0;
    test_reset();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      obs = {selection, grant, active, slot_start, frame_start};
      vectors++;
      if (obs !== 7'b0) begin
        miscompares++;
        $display("FAIL all_zero_idle cycle %0d: got %b, expected %b", i, obs, 7'b0);
      end
    end
    delta[2] = 32'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {selection, grant, active, slot_start, frame_start};
      exp = pack_exp(2, 1'b1, (i % 3) == 0, (i % 3) == 0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL all_zero_wake cycle %0d: got %b, expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [6:0] obs, exp;
    delta = {32'd1, 32'd4, 32'd2, 32'd3};
    test_reset();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    obs = {selection, grant, active, slot_start, frame_start};
    exp = pack_exp(2, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL in_slot2: got %b, expected %b", obs, exp);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (grant !== 2'd0) begin
      miscompares++;
      $display("FAIL grant_during_reset: got %0d, expected 0", grant);
    end
    tick();
    obs = {selection, grant, active, slot_start, frame_start};
    vectors++;
    if (obs !== 7'b0) begin
      miscompares++;
      $display("FAIL mid_reset_clear: got %b, expected %b", obs, 7'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {selection, grant, active, slot_start, frame_start};
      exp = pack_exp((i < 3) ? 0 : 1, 1'b1, (i == 0) || (i == 3), i == 0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reload_after_reset cycle %0d: got %b, expected %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_work_conserving();
    logic [1:0] exp_g;
    delta   = {32'd1, 32'd4, 32'd2, 32'd3};
    pending = 4'b0000;
    test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (selection !== 2'd1) begin
      miscompares++;
      $display("FAIL wc_selection: got %0d, expected 1", selection);
    end
    pending = 4'b1001;
    #1;
`ifdef TDMA_WORK_CONSERVING_EN
    exp_g = 2'd3;
`else
    exp_g = 2'd1;
`endif
    vectors++;
    if (grant !== exp_g) begin
      miscompares++;
      $display("FAIL wc_lend: got %0d, expected %0d", grant, exp_g);
    end
    pending = 4'b0010;
    #1;
    vectors++;
    if (grant !== 2'd1) begin
      miscompares++;
      $display("FAIL wc_owner_pending: got %0d, expected 1", grant);
    end
    pending = 4'b0000;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    delta       = '0;
    pending     = 4'b0000;
    test_reset();
    test_basic_frame();
    test_zero_slots();
    test_shadow_update();
    test_all_zero();
    test_mid_frame_reset();
    test_work_conserving();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
